// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the 8-bit data memory bank between the CPU datapath (port 0) and the
// DMA/IO loader (port 1). One transaction is in flight at a time:
//   IDLE -> STROBE -> WAIT -> DONE -> IDLE
// The winning request's we/addr/wdata are latched when leaving IDLE. The bank
// is strobed for one cycle. The arbiter then waits WAIT_CYCLES and captures
// mem_rdata. Finally it pulses the winner's ack for one cycle. Every output is
// a register.
//
// Parameters:
//   ADDR_W       address width
//   DATA_W       data width
//   WAIT_CYCLES  cycles from strobe to valid mem_rdata (1..15)
//
// Ports:
//   clock, reset                        system clock, async active-low reset
//   cpu_req/we/addr/wdata -> cpu_ack    CPU requester (port 0)
//   dma_req/we/addr/wdata -> dma_ack    DMA/IO loader (port 1)
//   rdata                               read data, valid in the ack cycle
//   busy                                high whenever the FSM is not idle
//   mem_addr/mem_wdata/mem_we/mem_re    memory bank request side
//   mem_rdata                           memory bank read data
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin arbitration on simultaneous requests
//              undefined -> fixed priority, CPU wins ties
module mem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The 4-bit wait counter cannot represent anything outside 1..15.
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("mem_arbiter: WAIT_CYCLES must lie in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              grant_dma, grant_dma_next;
    logic              txn_we, txn_we_next;
    logic              pick_dma;
    logic              cpu_ack_next, dma_ack_next;
    logic [DATA_W-1:0] rdata_next;
    logic              busy_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_next;
    logic              mem_we_next, mem_re_next;

`ifdef ARB_RR_EN
    // Pointer names the port that wins a tie (0 = CPU). It toggles on every
    // grant, including grants to a lone requester.
    logic rr_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 1'b0;
        end else if (state == S_IDLE && (cpu_req || dma_req)) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    assign pick_dma = dma_req & (~cpu_req | rr_ptr);
`else
    assign pick_dma = dma_req & ~cpu_req;
`endif

    // State and output registers. Reset aborts any transaction immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            grant_dma <= 1'b0;
            txn_we    <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            grant_dma <= grant_dma_next;
            txn_we    <= txn_we_next;
            cpu_ack   <= cpu_ack_next;
            dma_ack   <= dma_ack_next;
            rdata     <= rdata_next;
            busy      <= busy_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            mem_we    <= mem_we_next;
            mem_re    <= mem_re_next;
        end
    end

    // Next-state logic. Because outputs are registered, each branch decides
    // what the outputs look like in the state being entered.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        grant_dma_next = grant_dma;
        txn_we_next    = txn_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        mem_we_next    = 1'b0;
        mem_re_next    = 1'b0;
        cpu_ack_next   = 1'b0;
        dma_ack_next   = 1'b0;
        rdata_next     = '0;

        case (state)
            S_IDLE: begin
                if (cpu_req || dma_req) begin
                    state_next     = S_STROBE;
                    grant_dma_next = pick_dma;
                    txn_we_next    = pick_dma ? dma_we : cpu_we;
                    mem_addr_next  = pick_dma ? dma_addr : cpu_addr;
                    mem_wdata_next = pick_dma ? dma_wdata : cpu_wdata;
                    mem_we_next    = pick_dma ? dma_we : cpu_we;
                    mem_re_next    = pick_dma ? ~dma_we : ~cpu_we;
                end
            end
            S_STROBE: begin
                state_next = S_WAIT;
                cnt_next   = 4'(WAIT_CYCLES);
            end
            S_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    // mem_rdata is valid at this edge. Writes return zero.
                    state_next   = S_DONE;
                    cpu_ack_next = ~grant_dma;
                    dma_ack_next = grant_dma;
                    rdata_next   = txn_we ? '0 : mem_rdata;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter, built with WAIT_CYCLES = 3.
//
// A bank model drives mem_rdata. The data is correct only in the cycle that
// lies WAIT_CYCLES after the read strobe; in every other cycle the model
// drives the inverted value.
//
// A transaction-level reference model predicts the outputs. It computes them
// from the cycle in which a request was sampled, not from the FSM state.
//
// Compile with +define+ARB_RR_EN to check the round-robin build.
module tb_mem_arbiter;

    localparam int W = 3;

    logic       clock;
    logic       reset;
    logic       cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic       cpu_ack, dma_ack, busy, mem_we, mem_re;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .rdata     (rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    // Bank model. It is updated on the falling edge so that its state is
    // settled before the DUT samples it on the rising edge.
    logic [7:0] bank_mem [256];
    int         bank_cnt  = -1;
    logic [7:0] bank_addr = 8'h00;
    bit         bank_init = 1'b0;

    always @(negedge clock) begin
        int         next_cnt;
        logic [7:0] next_addr;
        if (!bank_init) begin
            for (int a = 0; a < 256; a++) bank_mem[a] <= 8'(a) ^ 8'h5A;
            bank_mem[8'h3F] <= 8'h5C;
            bank_init <= 1'b1;
        end else if (mem_we) begin
            bank_mem[mem_addr] <= mem_wdata;
        end
        next_addr = mem_re ? mem_addr : bank_addr;
        if (mem_re) next_cnt = 0;
        else if (bank_cnt >= 0 && bank_cnt <= W) next_cnt = bank_cnt + 1;
        else next_cnt = -1;
        bank_cnt  <= next_cnt;
        bank_addr <= next_addr;
        mem_rdata <= (next_cnt == W) ? bank_mem[next_addr] : ~bank_mem[next_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    function automatic void check_bit(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endfunction

    function automatic void check_byte(string name, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s cycle %0d: got %02h expected %02h", name, cyc, act, exp);
        end
    endfunction

    // Reference model: the transaction in flight and a shadow of the bank.
    logic [7:0] ref_mem [256];
    int         t_start;
    bit         t_dma, t_we;
    logic [7:0] t_addr, t_wdata, t_rdata;
    bit         last_c_ack, last_d_ack;
`ifdef ARB_RR_EN
    bit         rr_turn_dma;
`endif

    task automatic model_reset();
        t_start    = -1;
        last_c_ack = 1'b0;
        last_d_ack = 1'b0;
`ifdef ARB_RR_EN
        rr_turn_dma = 1'b0;
`endif
    endtask

    // Called at each rising edge with the inputs of the cycle that is ending.
    task automatic model_sample();
        bit pick_dma;
        if (!reset) return;
        if (t_start >= 0 && cyc - t_start <= W + 2) return;
        if (!cpu_req && !dma_req) return;
        if (cpu_req && dma_req) begin
`ifdef ARB_RR_EN
            pick_dma = rr_turn_dma;
`else
            pick_dma = 1'b0;
`endif
        end else begin
            pick_dma = dma_req;
        end
`ifdef ARB_RR_EN
        rr_turn_dma = !rr_turn_dma;
`endif
        t_start = cyc;
        t_dma   = pick_dma;
        t_we    = pick_dma ? dma_we    : cpu_we;
        t_addr  = pick_dma ? dma_addr  : cpu_addr;
        t_wdata = pick_dma ? dma_wdata : cpu_wdata;
        if (t_we) ref_mem[t_addr] = t_wdata;
        else      t_rdata = ref_mem[t_addr];
    endtask

    // Compares the outputs of the current cycle with the model's prediction.
    // Offset 1 from the sampling cycle is the strobe cycle; offset W+2 is the
    // ack cycle.
    task automatic check_output();
        int   off;
        logic act, ack_now;
        off        = (t_start < 0) ? -1 : cyc - t_start;
        act        = (off >= 1 && off <= W + 2);
        ack_now    = (off == W + 2);
        last_c_ack = ack_now && !t_dma;
        last_d_ack = ack_now && t_dma;
        check_bit("busy", busy, act);
        check_bit("mem_we", mem_we, off == 1 && t_we);
        check_bit("mem_re", mem_re, off == 1 && !t_we);
        check_bit("cpu_ack", cpu_ack, last_c_ack);
        check_bit("dma_ack", dma_ack, last_d_ack);
        if (act) begin
            check_byte("mem_addr", mem_addr, t_addr);
            check_byte("mem_wdata", mem_wdata, t_wdata);
        end
        if (ack_now) check_byte("rdata", rdata, t_we ? 8'h00 : t_rdata);
    endtask

    task automatic check_all_zero(string tag);
        check_bit({tag, " busy"}, busy, 1'b0);
        check_bit({tag, " mem_we"}, mem_we, 1'b0);
        check_bit({tag, " mem_re"}, mem_re, 1'b0);
        check_bit({tag, " cpu_ack"}, cpu_ack, 1'b0);
        check_bit({tag, " dma_ack"}, dma_ack, 1'b0);
        check_byte({tag, " rdata"}, rdata, 8'h00);
        check_byte({tag, " mem_addr"}, mem_addr, 8'h00);
        check_byte({tag, " mem_wdata"}, mem_wdata, 8'h00);
    endtask

    task automatic run_cycle();
        @(negedge clock);
        check_output();
        @(posedge clock);
        model_sample();
        #1 cyc++;
    endtask

    // Random requesters. A port drops its request after its ack (as predicted
    // by the model) and occasionally gives up early. Fields change freely
    // while a transaction is in flight.
    task automatic apply_stimulus();
        if (cpu_req) begin
            if (last_c_ack || $urandom_range(0, 19) == 0) cpu_req = 1'b0;
        end else begin
            cpu_req = ($urandom_range(0, 2) == 0);
        end
        if (dma_req) begin
            if (last_d_ack || $urandom_range(0, 19) == 0) dma_req = 1'b0;
        end else begin
            dma_req = ($urandom_range(0, 2) == 0);
        end
        cpu_we    = 1'($urandom);
        dma_we    = 1'($urandom);
        cpu_addr  = 8'($urandom_range(0, 15));
        dma_addr  = 8'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
        dma_wdata = 8'($urandom);
    endtask

    typedef struct {
        logic       c_req, c_we;
        logic [7:0] c_addr, c_wdata;
        logic       d_req, d_we;
        logic [7:0] d_addr, d_wdata;
        logic       e_busy, e_we, e_re;
        logic [7:0] e_addr, e_wdata;
        logic       e_cack, e_dack;
        logic [7:0] e_rdata;
        logic       chk_bus, chk_rdata;
    } vec_t;

    function automatic vec_t mk(logic cr, cw, logic [7:0] ca, cd,
                                logic dr, dw, logic [7:0] da, dd,
                                logic eb, ew, er, logic [7:0] ea, ed,
                                logic ec, edk, logic [7:0] erd, logic cb, crd);
        vec_t v;
        v.c_req = cr;  v.c_we = cw;  v.c_addr = ca;  v.c_wdata = cd;
        v.d_req = dr;  v.d_we = dw;  v.d_addr = da;  v.d_wdata = dd;
        v.e_busy = eb; v.e_we = ew;  v.e_re = er;
        v.e_addr = ea; v.e_wdata = ed;
        v.e_cack = ec; v.e_dack = edk; v.e_rdata = erd;
        v.chk_bus = cb; v.chk_rdata = crd;
        return v;
    endfunction

    vec_t vecs [20];

    initial begin
        logic exp_c, exp_d, exp_b;

        clock = 1'b0;
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
        model_reset();
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a) ^ 8'h5A;
        ref_mem[8'h3F] = 8'h5C;

        // Per-cycle vectors for WAIT_CYCLES = 3. Each row is one cycle:
        // inputs, then the expected registered outputs of that same cycle.
        //          cpu req/we/addr/wdata   dma req/we/addr/wdata   busy we re addr wdata cack dack rdata chkbus chkrd
        vecs[0]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,8'h00, 1,0);
        vecs[1]  = mk(1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,8'h00, 1,0);
        vecs[2]  = mk(1,1,8'h99,8'h00, 0,0,8'h00,8'h00, 1,1,0,8'h10,8'hA5, 0,0,8'h00, 1,0);
        vecs[3]  = mk(1,0,8'h99,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'hA5, 0,0,8'h00, 1,0);
        vecs[4]  = mk(1,0,8'h99,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'hA5, 0,0,8'h00, 1,0);
        vecs[5]  = mk(1,0,8'h99,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'hA5, 0,0,8'h00, 1,0);
        vecs[6]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'hA5, 1,0,8'h00, 1,1);
        vecs[7]  = mk(1,0,8'h10,8'h33, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,8'h00, 0,0);
        vecs[8]  = mk(1,0,8'h77,8'h33, 0,0,8'h00,8'h00, 1,0,1,8'h10,8'h33, 0,0,8'h00, 1,0);
        vecs[9]  = mk(1,1,8'h77,8'hEE, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'h33, 0,0,8'h00, 1,0);
        vecs[10] = mk(1,1,8'h77,8'hEE, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'h33, 0,0,8'h00, 1,0);
        vecs[11] = mk(1,1,8'h77,8'hEE, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'h33, 0,0,8'h00, 1,0);
        vecs[12] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'h33, 1,0,8'hA5, 1,1);
        vecs[13] = mk(0,0,8'h00,8'h00, 1,0,8'h3F,8'h00, 0,0,0,8'h00,8'h00, 0,0,8'h00, 0,0);
        vecs[14] = mk(0,0,8'h00,8'h00, 0,1,8'h11,8'h22, 1,0,1,8'h3F,8'h00, 0,0,8'h00, 1,0);
        vecs[15] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h3F,8'h00, 0,0,8'h00, 1,0);
        vecs[16] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h3F,8'h00, 0,0,8'h00, 1,0);
        vecs[17] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h3F,8'h00, 0,0,8'h00, 1,0);
        vecs[18] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h3F,8'h00, 0,1,8'h5C, 1,1);
        vecs[19] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,8'h00, 0,0);

        // Reset held with random inputs: every output must stay zero.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            @(negedge clock);
            check_all_zero("reset");
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        cpu_req = 1'b0; dma_req = 1'b0;
        model_reset();

        // Directed vectors: CPU write, CPU read with the address changed
        // mid-flight, and a DMA read whose request drops before the ack.
        for (int i = 0; i < 20; i++) begin
            cpu_req = vecs[i].c_req; cpu_we = vecs[i].c_we;
            cpu_addr = vecs[i].c_addr; cpu_wdata = vecs[i].c_wdata;
            dma_req = vecs[i].d_req; dma_we = vecs[i].d_we;
            dma_addr = vecs[i].d_addr; dma_wdata = vecs[i].d_wdata;
            @(negedge clock);
            check_bit($sformatf("tbl%0d busy", i), busy, vecs[i].e_busy);
            check_bit($sformatf("tbl%0d mem_we", i), mem_we, vecs[i].e_we);
            check_bit($sformatf("tbl%0d mem_re", i), mem_re, vecs[i].e_re);
            check_bit($sformatf("tbl%0d cpu_ack", i), cpu_ack, vecs[i].e_cack);
            check_bit($sformatf("tbl%0d dma_ack", i), dma_ack, vecs[i].e_dack);
            if (vecs[i].chk_bus) begin
                check_byte($sformatf("tbl%0d mem_addr", i), mem_addr, vecs[i].e_addr);
                check_byte($sformatf("tbl%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
            if (vecs[i].chk_rdata) check_byte($sformatf("tbl%0d rdata", i), rdata, vecs[i].e_rdata);
            @(posedge clock);
            model_sample();
            #1 cyc++;
        end

        // Short reset pulse so that the arbitration pointer starts at the CPU.
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        cyc++;

        // Both ports hold read requests. Acks land every W+3 cycles.
        for (int k = 0; k < 18; k++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20; cpu_wdata = 8'h00;
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h21; dma_wdata = 8'h00;
`ifdef ARB_RR_EN
            exp_c = (k == 5) || (k == 17);
            exp_d = (k == 11);
`else
            exp_c = (k == 5) || (k == 11) || (k == 17);
            exp_d = 1'b0;
`endif
            exp_b = !(k == 0 || k == 6 || k == 12);
            @(negedge clock);
            check_bit($sformatf("both k%0d cpu_ack", k), cpu_ack, exp_c);
            check_bit($sformatf("both k%0d dma_ack", k), dma_ack, exp_d);
            check_bit($sformatf("both k%0d busy", k), busy, exp_b);
            if (exp_c) check_byte($sformatf("both k%0d rdata", k), rdata, 8'h7A);
            if (exp_d) check_byte($sformatf("both k%0d rdata", k), rdata, 8'h7B);
            @(posedge clock);
            model_sample();
            #1 cyc++;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        run_cycle();

        // Reset asserted in WAIT: outputs clear at once, the transaction is
        // dropped, and the still-held request is served again from IDLE.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30; cpu_wdata = 8'h00;
        run_cycle();
        run_cycle();
        run_cycle();
        @(negedge clock);
        check_output();
        #2 reset = 1'b0;
        model_reset();
        #1 check_all_zero("abort");
        @(posedge clock);
        #1 cyc++;
        @(negedge clock);
        check_output();
        #2 reset = 1'b1;
        @(posedge clock);
        model_sample();
        #1 cyc++;
        for (int i = 0; i < W + 4; i++) run_cycle();

        // Random traffic checked against the reference model.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus();
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the 8-bit data memory bank between two requesters: the CPU datapath (port 0) and a DMA/IO loader (port 1).
- Accepts one transaction at a time and drives the bank's address, write-data and read/write strobes.
- Waits the bank's fixed read latency, then returns read data with a one-cycle acknowledge to the winning requester.
- Sits between the CPU's memory stage, the loader and the memory bank.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- WAIT_CYCLES, 1, cycles from strobe to valid mem_rdata; legal range 1..15.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack: same as the CPU set, for port 1.
- rdata  out  DATA_W  read data; valid only in an ack cycle.
- busy  out  1  high when state is not IDLE.
- mem_addr  out  ADDR_W  bank address.
- mem_wdata  out  DATA_W  bank write data.
- mem_we  out  1  bank write strobe.
- mem_re  out  1  bank read strobe.
- mem_rdata  in  DATA_W  bank read data, valid WAIT_CYCLES after the strobe cycle.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, active-low):
  - state = IDLE.
  - All outputs = 0, including busy, acks and strobes.
  - Priority pointer selects the CPU.
- State machine: IDLE -> STROBE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Samples cpu_req and dma_req.
  - If either is high, choose a winner, latch its we/addr/wdata and the grant id, go to STROBE.
  - No request: stay in IDLE.
- STROBE: exactly one cycle.
  - mem_addr and mem_wdata carry the latched values.
  - Exactly one of mem_we or mem_re is high.
  - Counter loads WAIT_CYCLES; next state WAIT.
- WAIT:
  - Strobes low; mem_addr and mem_wdata hold their values.
  - Counter decrements each cycle.
  - In the cycle the counter equals 1, capture mem_rdata at the edge and go to DONE.
  - Writes use the same timing; captured data is don't-care and rdata is driven to 0.
- DONE: one cycle.
  - The granted port's ack = 1; rdata is valid (reads).
  - Requests are not sampled in DONE; next state IDLE.
- Latency:
  - Request sampled at the end of cycle R: strobe in R+1, ack in R+WAIT_CYCLES+2.
  - Back-to-back requests from one port: next strobe no earlier than ack+2.
- Requester protocol:
  - A request dropped before its ack still completes; the ack still pulses.
  - A request changed mid-transaction does not affect the latched values.
- Default arbitration is fixed priority: CPU wins when both requests are high.
- Reset asserted mid-transaction: immediate return to IDLE, strobes and ack cleared, transaction aborted, no ack after release.
- WAIT_CYCLES outside 1..15: elaboration error.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer flips to the other port after each grant, at the IDLE->STROBE transition.
  - On a tie, the pointed-to port wins.
  - A lone requester always wins and the pointer still updates.
- Undefined: fixed CPU priority; no pointer logic.

Test Plan:
- Reset with random inputs -> all outputs 0 and busy = 0; no strobe until reset is released and a request is seen.
- CPU write addr 0x10, data 0xA5, WAIT_CYCLES = 1, req sampled in R -> mem_we = 1 only in R+1 with mem_addr 0x10 and mem_wdata 0xA5; cpu_ack in R+3; dma_ack stays 0.
- CPU read of 0x10, bank model returns 0xA5 -> mem_re = 1 only in R+1; cpu_ack with rdata = 0xA5 in R+3.
- cpu_req and dma_req both held high from R (reads, WAIT_CYCLES = 1):
  - Without ARB_RR_EN -> cpu_ack in R+3, R+7, R+11; dma_ack never.
  - With ARB_RR_EN -> acks alternate CPU, DMA, CPU.
- WAIT_CYCLES = 4, DMA read of 0x3F returning 0x5C -> dma_ack and rdata = 0x5C in R+6; busy high R+1..R+6.
- WAIT_CYCLES = 3, reset asserted during WAIT -> outputs 0 within the same cycle; no ack after release; the still-held request is re-served from IDLE with full latency.
